// File: rtl/spi_reg_bank_if.sv
// Byte-stream handshake between the spi_slave front end and the register bank.
// The master side is the spi_slave (or a bench standing in for it).
interface spi_reg_bank_if;
  logic       ss_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_rx_data;
  logic [7:0] s_tx_data;

  modport master (
    output ss_n,
    output s_valid,
    output s_rx_data,
    input  s_ready,
    input  s_tx_data
  );

  modport slave (
    input  ss_n,
    input  s_valid,
    input  s_rx_data,
    output s_ready,
    output s_tx_data
  );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI command-frame decoder feeding a flat register file, with read-back,
// burst auto-increment, frame abort on ss_n and out-of-range detection.
module spi_reg_bank #(
  parameter int         ADDR_BYTES = 1,
  parameter int         DATA_BYTES = 4,
  parameter int         NUM_REGS   = 64,
  parameter int         AUTO_INC   = 1,
  parameter logic [7:0] CMD_WR     = 8'h5A,
  parameter logic [7:0] CMD_RD     = 8'hA5,
  localparam int        ADDR_W     = 8 * ADDR_BYTES,
  localparam int        DATA_W     = 8 * DATA_BYTES
) (
  input  logic                       clk,
  input  logic                       rstn,
  spi_reg_bank_if.slave              bus,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       addr_err
);

  localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WDATA  = 3'd2,
    S_COMMIT = 3'd3,
    S_RDATA  = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_dir_wr;
  logic [ADDR_W-1:0]           r_addr;
  logic [DATA_W-1:0]           r_buf;
  logic [7:0]                  r_tx;
  logic                        r_s_ready;
  logic                        r_wr_stb;
  logic                        r_addr_err;
  logic [ADDR_W-1:0]           r_wr_addr;
  logic [DATA_W-1:0]           r_wr_data;
  logic [NUM_REGS*DATA_W-1:0]  r_regs_flat;

  logic                        w_acc;
  logic                        w_is_cmd;
  logic                        w_addr_last;
  logic                        w_data_last;
  logic                        w_commit;
  logic [ADDR_W-1:0]           w_addr_asm;
  logic [ADDR_W-1:0]           w_addr_inc;
  logic [DATA_W-1:0]           w_buf_asm;
  logic [DATA_W-1:0]           w_cur_word;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic                        w_dir_nxt;
  logic [ADDR_W-1:0]           w_addr_nxt;
  logic [DATA_W-1:0]           w_buf_nxt;
  logic [7:0]                  w_tx_nxt;
  logic                        w_wr_stb_nxt;
  logic                        w_addr_err_nxt;
  logic [ADDR_W-1:0]           w_wr_addr_nxt;
  logic [DATA_W-1:0]           w_wr_data_nxt;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS));
  endfunction

  // Out-of-range addresses read back as all zeros.
  function automatic logic [DATA_W-1:0] reg_word(input logic [NUM_REGS*DATA_W-1:0] f,
                                                 input logic [ADDR_W-1:0]          a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) w = f[i*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] w,
                                          input logic [CNT_W-1:0]  k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (k == CNT_W'(i)) b = w[i*8 +: 8];
    end
    return b;
  endfunction

  assign w_acc       = bus.s_valid && r_s_ready;
  assign w_is_cmd    = (bus.s_rx_data == CMD_WR) || (bus.s_rx_data == CMD_RD);
  assign w_addr_last = (r_cnt == CNT_W'(ADDR_BYTES - 1));
  assign w_data_last = (r_cnt == CNT_W'(DATA_BYTES - 1));
  assign w_addr_inc  = ({1'b0, r_addr} == (ADDR_W + 1)'(NUM_REGS - 1)) ? '0 : r_addr + ADDR_W'(1);
  assign w_cur_word  = reg_word(r_regs_flat, r_addr);
  // The register write is already announced by wr_stb, so a late ss_n cannot cancel it.
  assign w_commit    = (r_state == S_COMMIT) && in_range(r_addr);

  // Drop the incoming byte into its LSB-first slot of the address and data buffers.
  always_comb begin
    w_addr_asm = r_addr;
    w_buf_asm  = r_buf;
    for (int b = 0; b < ADDR_BYTES; b++) begin
      if (r_cnt == CNT_W'(b)) begin
        w_addr_asm[b*8 +: 8] = bus.s_rx_data;
      end else begin
        w_addr_asm[b*8 +: 8] = r_addr[b*8 +: 8];
      end
    end
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (r_cnt == CNT_W'(b)) begin
        w_buf_asm[b*8 +: 8] = bus.s_rx_data;
      end else begin
        w_buf_asm[b*8 +: 8] = r_buf[b*8 +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; ss_n high aborts from anywhere.
  always_comb begin
    w_next = r_state;
    if (bus.ss_n) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc && w_is_cmd) w_next = S_ADDR;
          else                   w_next = S_IDLE;
        end
        S_ADDR: begin
          if (w_acc && w_addr_last) w_next = r_dir_wr ? S_WDATA : S_RDATA;
          else                      w_next = S_ADDR;
        end
        S_WDATA: begin
          if (w_acc && w_data_last) w_next = S_COMMIT;
          else                      w_next = S_WDATA;
        end
        S_COMMIT: begin
          if (AUTO_INC != 0) w_next = S_WDATA;
          else               w_next = S_IDLE;
        end
        S_RDATA: begin
          if (w_acc && w_data_last && (AUTO_INC == 0)) w_next = S_IDLE;
          else                                         w_next = S_RDATA;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Next values of the datapath registers and the registered outputs.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_dir_nxt      = r_dir_wr;
    w_addr_nxt     = r_addr;
    w_buf_nxt      = r_buf;
    w_tx_nxt       = r_tx;
    w_wr_stb_nxt   = 1'b0;
    w_addr_err_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    if (bus.ss_n) begin
      w_cnt_nxt = '0;
      w_buf_nxt = '0;
      w_tx_nxt  = 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (w_acc && w_is_cmd) w_dir_nxt = (bus.s_rx_data == CMD_WR);
          else                   w_dir_nxt = r_dir_wr;
        end
        S_ADDR: begin
          if (w_acc) begin
            w_addr_nxt = w_addr_asm;
            if (w_addr_last) begin
              w_cnt_nxt = '0;
              if (!r_dir_wr) begin
                w_tx_nxt       = byte_sel(reg_word(r_regs_flat, w_addr_asm), '0);
                w_addr_err_nxt = !in_range(w_addr_asm);
              end else begin
                w_tx_nxt = 8'h00;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_addr_nxt = r_addr;
          end
        end
        S_WDATA: begin
          if (w_acc) begin
            w_buf_nxt = w_buf_asm;
            if (w_data_last) begin
              w_cnt_nxt = '0;
              if (in_range(r_addr)) begin
                w_wr_stb_nxt  = 1'b1;
                w_wr_addr_nxt = r_addr;
                w_wr_data_nxt = w_buf_asm;
              end else begin
                w_addr_err_nxt = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_buf_nxt = r_buf;
          end
        end
        S_COMMIT: begin
          if (AUTO_INC != 0) w_addr_nxt = w_addr_inc;
          else               w_addr_nxt = r_addr;
        end
        S_RDATA: begin
          if (w_acc) begin
            if (w_data_last) begin
              w_cnt_nxt = '0;
              if (AUTO_INC != 0) begin
                w_addr_nxt = w_addr_inc;
                w_tx_nxt   = byte_sel(reg_word(r_regs_flat, w_addr_inc), '0);
              end else begin
                w_tx_nxt = 8'h00;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
              w_tx_nxt  = byte_sel(w_cur_word, r_cnt + CNT_W'(1));
            end
          end else begin
            w_tx_nxt = r_tx;
          end
        end
        default: begin
          w_cnt_nxt = '0;
          w_tx_nxt  = 8'h00;
        end
      endcase
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_dir_wr   <= 1'b0;
      r_addr     <= '0;
      r_buf      <= '0;
      r_tx       <= 8'h00;
      r_s_ready  <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_addr_err <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_dir_wr   <= w_dir_nxt;
      r_addr     <= w_addr_nxt;
      r_buf      <= w_buf_nxt;
      r_tx       <= w_tx_nxt;
      r_s_ready  <= (w_next != S_COMMIT);
      r_wr_stb   <= w_wr_stb_nxt;
      r_addr_err <= w_addr_err_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  // Register file, written at the end of the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_regs_flat <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_addr == ADDR_W'(i)) r_regs_flat[i*DATA_W +: DATA_W] <= r_buf;
      end
    end else begin
      r_regs_flat <= r_regs_flat;
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.s_tx_data = r_tx;
  assign regs_flat     = r_regs_flat;
  assign wr_stb        = r_wr_stb;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign addr_err      = r_addr_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank (1 address byte, 4 data bytes, 64 regs, auto-increment).
module tb_spi_reg_bank;
  localparam int NUM_REGS = 64;
  localparam int DATA_W   = 32;

  logic                       clk;
  logic                       rstn;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       wr_stb;
  logic [7:0]                 wr_addr;
  logic [31:0]                wr_data;
  logic                       addr_err;

  spi_reg_bank_if bus ();

  spi_reg_bank #(
    .ADDR_BYTES (1),
    .DATA_BYTES (4),
    .NUM_REGS   (NUM_REGS),
    .AUTO_INC   (1),
    .CMD_WR     (8'h5A),
    .CMD_RD     (8'hA5)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .regs_flat (regs_flat),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int mon_stb  = 0;
  int mon_err  = 0;
  int mon_both = 0;
  logic [7:0]  mon_addr [$];
  logic [31:0] mon_data [$];
  logic [NUM_REGS*DATA_W-1:0] exp_regs;

  // Pulse monitor: records every strobe and error pulse away from the clock edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (wr_stb) begin
        mon_stb++;
        mon_addr.push_back(wr_addr);
        mon_data.push_back(wr_data);
      end
      if (addr_err) mon_err++;
      if (wr_stb && addr_err) mon_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    int idx;
    idx = 0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (regs_flat[i*DATA_W +: DATA_W] !== exp_regs[i*DATA_W +: DATA_W]) idx = i;
    end
    n_vec++;
    assert (regs_flat === exp_regs) else begin
      n_fail++;
      $error("FAIL %s: reg%0d observed 0x%h expected 0x%h", tag, idx,
             regs_flat[idx*DATA_W +: DATA_W], exp_regs[idx*DATA_W +: DATA_W]);
    end
  endtask

  // One byte transfer; miso is what the slave drove during that transfer.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
    int n;
    @(negedge clk);
    bus.s_valid   = 1'b1;
    bus.s_rx_data = b;
    n = 0;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      n_vec++;
      n_fail++;
      $error("FAIL ready_timeout: observed s_ready 0 expected 1 for byte 0x%0h", b);
    end
    miso = bus.s_tx_data;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] m;
    send_byte(8'h5A, m);
    send_byte(a, m);
    for (int k = 0; k < 4; k++) send_byte(d[k*8 +: 8], m);
  endtask

  task automatic rd_frame(input logic [7:0] a, output logic [31:0] d);
    logic [7:0] m;
    send_byte(8'hA5, m);
    send_byte(a, m);
    for (int k = 0; k < 4; k++) begin
      send_byte(8'hFF, m);
      d[k*8 +: 8] = m;
    end
  endtask

  task automatic frame_end();
    @(negedge clk);
    bus.ss_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.ss_n = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  m;
    int          s0;
    int          e0;
    exp_regs      = '0;
    rstn          = 1'b0;
    bus.ss_n      = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_rx_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.s_ready}, 32'd0);
    check("rst_tx", {24'd0, bus.s_tx_data}, 32'h00);
    check("rst_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    check("rst_waddr", {24'd0, wr_addr}, 32'd0);
    check("rst_wdata", wr_data, 32'd0);
    check_regs("rst_regs");
    rstn = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, bus.s_ready}, 32'd1);
    bus.ss_n = 1'b0;

    // 1: single write, strobe timing and register update latency
    wr_frame(8'h10, 32'h12345678);
    @(negedge clk);
    check("t1_stb", {31'd0, wr_stb}, 32'd1);
    check("t1_waddr", {24'd0, wr_addr}, 32'h10);
    check("t1_wdata", wr_data, 32'h12345678);
    check("t1_ready_commit", {31'd0, bus.s_ready}, 32'd0);
    check_regs("t1_regs_before");
    exp_regs[16*DATA_W +: DATA_W] = 32'h12345678;
    @(negedge clk);
    check("t1_stb_low", {31'd0, wr_stb}, 32'd0);
    check_regs("t1_regs_after");
    frame_end();

    // 2: read back
    s0 = mon_stb;
    rd_frame(8'h10, rd);
    frame_end();
    check("t2_rdata", rd, 32'h12345678);
    check("t2_no_stb", mon_stb - s0, 32'd0);
    check("t2_tx_idle", {24'd0, bus.s_tx_data}, 32'h00);

    // 3: burst across the top register wraps to reg0
    s0 = mon_stb;
    send_byte(8'h5A, m);
    send_byte(8'h3F, m);
    for (int k = 1; k <= 8; k++) send_byte(8'((k << 4) | k), m);
    frame_end();
    exp_regs[63*DATA_W +: DATA_W] = 32'h44332211;
    exp_regs[0 +: DATA_W]         = 32'h88776655;
    check("t3_stb_cnt", mon_stb - s0, 32'd2);
    check("t3_addr0", {24'd0, mon_addr[s0]}, 32'h3F);
    check("t3_addr1", {24'd0, mon_addr[s0+1]}, 32'h00);
    check("t3_data1", mon_data[s0+1], 32'h88776655);
    check_regs("t3_regs");

    // 4: out-of-range write and read
    s0 = mon_stb;
    e0 = mon_err;
    wr_frame(8'h40, 32'h04030201);
    frame_end();
    check("t4_wr_err", mon_err - e0, 32'd1);
    check("t4_wr_no_stb", mon_stb - s0, 32'd0);
    check_regs("t4_regs");
    e0 = mon_err;
    rd_frame(8'h40, rd);
    frame_end();
    check("t4_rd_zero", rd, 32'h0);
    check("t4_rd_err", mon_err - e0, 32'd1);

    // 5: aborted frame, then stray byte before a good frame
    s0 = mon_stb;
    send_byte(8'h5A, m);
    send_byte(8'h05, m);
    send_byte(8'hAA, m);
    send_byte(8'hBB, m);
    frame_end();
    check("t5_abort_no_stb", mon_stb - s0, 32'd0);
    check_regs("t5_abort_regs");
    send_byte(8'h00, m);
    wr_frame(8'h05, 32'h0A0B0C0D);
    frame_end();
    exp_regs[5*DATA_W +: DATA_W] = 32'h0A0B0C0D;
    check("t5_stb_cnt", mon_stb - s0, 32'd1);
    check("t5_waddr", {24'd0, mon_addr[s0]}, 32'h05);
    check_regs("t5_regs");

    // ss_n rising together with the last data byte drops the write
    s0 = mon_stb;
    e0 = mon_err;
    send_byte(8'h5A, m);
    send_byte(8'h06, m);
    send_byte(8'h01, m);
    send_byte(8'h02, m);
    send_byte(8'h03, m);
    bus.ss_n = 1'b1;
    send_byte(8'h04, m);
    repeat (2) @(negedge clk);
    bus.ss_n = 1'b0;
    check("ssn_prio_no_stb", mon_stb - s0, 32'd0);
    check("ssn_prio_no_err", mon_err - e0, 32'd0);
    check_regs("ssn_prio_regs");

    // 6: reset in the middle of WDATA
    wr_frame(8'h02, 32'hDEADBEEF);
    frame_end();
    exp_regs[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    check_regs("t6_pre_regs");
    send_byte(8'h5A, m);
    send_byte(8'h03, m);
    send_byte(8'h11, m);
    send_byte(8'h22, m);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    exp_regs = '0;
    check_regs("t6_rst_regs");
    check("t6_rst_stb", {31'd0, wr_stb}, 32'd0);
    check("t6_rst_ready", {31'd0, bus.s_ready}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("t6_idle_ready", {31'd0, bus.s_ready}, 32'd1);
    s0 = mon_stb;
    wr_frame(8'h07, 32'hCAFEF00D);
    frame_end();
    exp_regs[7*DATA_W +: DATA_W] = 32'hCAFEF00D;
    check("t6_post_stb", mon_stb - s0, 32'd1);
    check_regs("t6_post_regs");

    check("stb_err_exclusive", mon_both, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
